cu_mem_arbiter: RTL and testbench
=================================

Name: cu_mem_arbiter

Overview:
- Shares one global data-memory port among NUM_CU compute_unit_top instances.
- Round-robin arbitration of per-CU request channels (valid/ready, is_load, addr, wdata, rd) into one registered downstream request.
- Downstream memory returns load responses in order. A tag FIFO of requester IDs routes each response back to the CU that issued it.
- Sits between the CU array and the global memory / interconnect.

Parameters:
- NUM_CU, 4, number of requesting compute units (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_W, 5, destination-register tag width.
- MAX_OUTSTANDING, 16, tag FIFO depth (power of 2); maximum loads in flight.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cu_req_valid  in  NUM_CU  per-CU request valid
- cu_req_is_load  in  NUM_CU  1=load, 0=store
- cu_req_addr  in  NUM_CU*ADDR_W  packed per-CU address
- cu_req_wdata  in  NUM_CU*DATA_W  packed store data
- cu_req_rd  in  NUM_CU*RD_W  packed load destination tag
- cu_req_ready  out  NUM_CU  request accepted this cycle
- cu_resp_valid  out  NUM_CU  one-hot load response
- cu_resp_rd  out  RD_W  response rd (shared by all CUs, qualified by cu_resp_valid)
- cu_resp_data  out  DATA_W  response data (shared, qualified by cu_resp_valid)
- mem_req_valid  out  1  downstream request valid
- mem_req_is_load  out  1
- mem_req_addr  out  ADDR_W
- mem_req_wdata  out  DATA_W
- mem_req_rd  out  RD_W
- mem_req_ready  in  1  downstream accepts
- mem_resp_valid  in  1  in-order load response
- mem_resp_rd  in  RD_W
- mem_resp_data  in  DATA_W
- err_resp_underflow  out  1  sticky: response arrived with tag FIFO empty

Behaviour:
- Reset (synchronous): all outputs 0, output register empty, tag FIFO empty, RR pointer = 0 (CU0 highest priority), err cleared.
- Output register (1 entry) holds the downstream request; mem_req_* driven directly from it.
  - It can load when empty, or when mem_req_valid && mem_req_ready in the same cycle (full throughput, 1 req/cycle).
- Eligibility:
  - CU i is eligible if cu_req_valid[i] and (store, or tag FIFO not full).
  - Full means count == MAX_OUTSTANDING. A same-cycle pop does NOT free a slot for a push.
- Grant:
  - Among eligible CUs, the first at or after rr_ptr (wrapping) wins, only when the output register can load.
  - cu_req_ready is one-hot or zero; it is combinational from valid, FIFO state and mem_req_ready.
  - On grant: rr_ptr <= winner+1 mod NUM_CU. With no grant, rr_ptr holds.
  - A valid CU not granted keeps its request stable; no starvation (bounded by NUM_CU grants).
- Request latency: accepted at edge N, mem_req_valid=1 from cycle N+1.
- Tag FIFO push: on acceptance of a load, the winner ID is pushed. Stores push nothing and receive no response.
- Response path:
  - On mem_resp_valid, pop the FIFO head h.
  - Next cycle: cu_resp_valid = 1<<h, cu_resp_rd = mem_resp_rd, cu_resp_data = mem_resp_data. This is a 1-cycle registered latency, pulsed for 1 cycle.
  - Push and pop may occur in the same cycle; count is unchanged.
- Underflow: mem_resp_valid with FIFO empty sets err_resp_underflow (sticky until reset); the response is dropped and no cu_resp_valid is asserted.
- Reset mid-operation: in-flight request and tags are discarded. Stale responses after reset follow the underflow rule.
- Order: responses to each CU arrive in that CU's issue order; cross-CU order follows downstream order.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant_cnt (NUM_CU*32): per-CU accepted requests.
  - Adds perf_stall_cnt (32): cycles with ≥1 valid CU and no grant.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef mem_req_t {is_load, addr, wdata, rd}
  - typedef cu_id_t (logic [$clog2(NUM_CU)-1:0])
  - constants for default widths.
- Sub-module mem_arb_tag_fifo: synchronous FIFO of cu_id_t, with push, pop, full, empty, count.

Test Plan:
- All 4 CUs hold a valid load continuously, mem always ready, resp 3 cycles later → grants 0,1,2,3,0,… each CU gets cu_resp_valid with its own rd/data, 1 req/cycle sustained.
- CU2 issues a store to FFFF_F9F0, wdata=1, simultaneously with a CU1 load → both forwarded in RR order; only CU1 gets a response; FIFO count returns to 0.
- mem_req_ready=0 for 5 cycles with CU0 valid → mem_req_* stable, cu_req_ready=0 throughout; after release, accepted the next cycle.
- 16 loads outstanding with no responses → 17th load not granted; a store from another CU is still granted; one response frees the slot the following cycle.
- mem_resp_valid with FIFO empty → err_resp_underflow=1 sticky, no cu_resp_valid.
- Assert rst_n=0 with 3 loads in flight → all outputs 0 next cycle; a later stale response sets underflow.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the CU memory arbiter
package mem_arb_pkg;

    localparam int DEF_NUM_CU          = 4;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_RD_W            = 5;
    localparam int DEF_MAX_OUTSTANDING = 16;

    typedef logic [$clog2(DEF_NUM_CU)-1:0] cu_id_t;

    typedef struct packed {
        logic                  is_load;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_RD_W-1:0]   rd;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// rtl/mem_arb_tag_fifo.sv - in-order FIFO of requester IDs for outstanding loads
module mem_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [ID_W-1:0]          push_id_i,
    input  logic                     pop_i,
    output logic [ID_W-1:0]          head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/cu_mem_arbiter.sv
// rtl/cu_mem_arbiter.sv - round-robin CU memory arbiter with in-order response routing (optional MEM_ARB_PERF_EN)
module cu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CU          = DEF_NUM_CU,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int RD_W            = DEF_RD_W,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CU-1:0]          cu_req_valid,
    input  logic [NUM_CU-1:0]          cu_req_is_load,
    input  logic [NUM_CU*ADDR_W-1:0]   cu_req_addr,
    input  logic [NUM_CU*DATA_W-1:0]   cu_req_wdata,
    input  logic [NUM_CU*RD_W-1:0]     cu_req_rd,
    output logic [NUM_CU-1:0]          cu_req_ready,
    output logic [NUM_CU-1:0]          cu_resp_valid,
    output logic [RD_W-1:0]            cu_resp_rd,
    output logic [DATA_W-1:0]          cu_resp_data,
    output logic                       mem_req_valid,
    output logic                       mem_req_is_load,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_wdata,
    output logic [RD_W-1:0]            mem_req_rd,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [RD_W-1:0]            mem_resp_rd,
    input  logic [DATA_W-1:0]          mem_resp_data,
    output logic                       err_resp_underflow
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NUM_CU*32-1:0]       perf_grant_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_CU);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CU - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic [ID_W-1:0]   fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    logic [NUM_CU-1:0] eligible;
    logic              found;
    logic              grant;
    logic              can_load;
    logic              resp_pop;
    logic [ID_W-1:0]   winner;
    logic              sel_is_load;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [RD_W-1:0]   sel_rd;

    logic [ID_W-1:0]   rr_ptr_q;
    logic              out_valid_q;
    logic              out_is_load_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_wdata_q;
    logic [RD_W-1:0]   out_rd_q;
    logic [NUM_CU-1:0] resp_valid_q;
    logic [RD_W-1:0]   resp_rd_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              err_q;

    assign can_load = !out_valid_q || mem_req_ready;

    // Loads need a free tag slot; a same-cycle pop does not count as free.
    always_comb begin
        int idx;
        eligible = cu_req_valid & ~(cu_req_is_load & {NUM_CU{fifo_full}});
        found    = 1'b0;
        winner   = '0;
        for (int k = 0; k < NUM_CU; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CU) begin
                idx = idx - NUM_CU;
            end
            if (!found && eligible[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign grant        = found && can_load && rst_n;
    assign cu_req_ready = grant ? (NUM_CU'(1) << winner) : '0;
    assign sel_is_load  = cu_req_is_load[winner];
    assign sel_addr     = cu_req_addr[winner*ADDR_W +: ADDR_W];
    assign sel_wdata    = cu_req_wdata[winner*DATA_W +: DATA_W];
    assign sel_rd       = cu_req_rd[winner*RD_W +: RD_W];
    assign resp_pop     = mem_resp_valid && !fifo_empty;

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (grant && sel_is_load),
        .push_id_i (winner),
        .pop_i     (resp_pop),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            out_addr_q    <= '0;
            out_wdata_q   <= '0;
            out_rd_q      <= '0;
        end else if (grant) begin
            rr_ptr_q      <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
            out_valid_q   <= 1'b1;
            out_is_load_q <= sel_is_load;
            out_addr_q    <= sel_addr;
            out_wdata_q   <= sel_wdata;
            out_rd_q      <= sel_rd;
        end else if (mem_req_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= resp_pop ? (NUM_CU'(1) << fifo_head) : '0;
            if (resp_pop) begin
                resp_rd_q   <= mem_resp_rd;
                resp_data_q <= mem_resp_data;
            end
            if (mem_resp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Eligibility gating must keep the tag count within the FIFO depth.
    assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(MAX_OUTSTANDING));

    assign mem_req_valid      = out_valid_q;
    assign mem_req_is_load    = out_is_load_q;
    assign mem_req_addr       = out_addr_q;
    assign mem_req_wdata      = out_wdata_q;
    assign mem_req_rd         = out_rd_q;
    assign cu_resp_valid      = resp_valid_q;
    assign cu_resp_rd         = resp_rd_q;
    assign cu_resp_data       = resp_data_q;
    assign err_resp_underflow = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [NUM_CU*32-1:0] perf_grant_q;
    logic [31:0]          perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CU; i++) begin
                if (cu_req_ready[i] && (perf_grant_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_grant_q[i*32 +: 32] <= perf_grant_q[i*32 +: 32] + 32'd1;
                end
            end
            if ((|cu_req_valid) && !grant && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = perf_grant_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_cu_mem_arbiter.sv
// tb/tb_cu_mem_arbiter.sv - randomized self-checking bench for cu_mem_arbiter
module tb_cu_mem_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  cu_req_valid, cu_req_is_load, cu_req_ready, cu_resp_valid;
    logic [N*32-1:0] cu_req_addr, cu_req_wdata;
    logic [N*5-1:0]  cu_req_rd;
    logic [4:0]    cu_resp_rd, mem_req_rd, mem_resp_rd;
    logic [31:0]   cu_resp_data, mem_req_addr, mem_req_wdata, mem_resp_data;
    logic          mem_req_valid, mem_req_is_load, mem_req_ready, mem_resp_valid;
    logic          err_resp_underflow;
`ifdef MEM_ARB_PERF_EN
    logic [N*32-1:0] perf_grant_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    cu_mem_arbiter #(
        .NUM_CU(N), .ADDR_W(32), .DATA_W(32), .RD_W(5), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cu_req_valid(cu_req_valid), .cu_req_is_load(cu_req_is_load),
        .cu_req_addr(cu_req_addr), .cu_req_wdata(cu_req_wdata), .cu_req_rd(cu_req_rd),
        .cu_req_ready(cu_req_ready), .cu_resp_valid(cu_resp_valid),
        .cu_resp_rd(cu_resp_rd), .cu_resp_data(cu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_is_load(mem_req_is_load),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_rd(mem_req_rd),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rd(mem_resp_rd), .mem_resp_data(mem_resp_data),
        .err_resp_underflow(err_resp_underflow)
`ifdef MEM_ARB_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Each CU holds one pending request until the reference says it was granted.
    logic        p_v [N];
    logic        p_ld[N];
    logic [31:0] p_addr[N], p_wd[N];
    logic [4:0]  p_rd[N];
    int gen_pct, load_pct, rdy_pct, resp_pct, lat;
    bit resp_en, force_resp;

    // Reference: one downstream slot, a queue of requester IDs, one-cycle response pulse.
    int          rr;
    bit          mo_v, mo_ld;
    logic [31:0] mo_addr, mo_wd;
    logic [4:0]  mo_rd;
    int          tags[$];
    logic [N-1:0] mr_v;
    logic [4:0]  mr_rd;
    logic [31:0] mr_data;
    bit          m_err;

    typedef struct { logic [4:0] rd; logic [31:0] data; int due; } mresp_t;
    mresp_t mq[$];

    task automatic model_reset();
        rr = 0; mo_v = 0; mo_ld = 0; mo_addr = '0; mo_wd = '0; mo_rd = '0;
        tags.delete(); mr_v = '0; mr_rd = '0; mr_data = '0; m_err = 0;
    endtask

    task automatic drive_cu();
        for (int i = 0; i < N; i++) begin
            cu_req_valid[i]          = p_v[i];
            cu_req_is_load[i]        = p_ld[i];
            cu_req_addr[i*32 +: 32]  = p_addr[i];
            cu_req_wdata[i*32 +: 32] = p_wd[i];
            cu_req_rd[i*5 +: 5]      = p_rd[i];
        end
    endtask

    task automatic step();
        bit full, can_load, fire;
        int win, j, h;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        full     = (tags.size() >= MAXO);
        can_load = !mo_v || mem_req_ready;
        win      = -1;
        if (rst_n && can_load) begin
            for (int k = 0; k < N; k++) begin
                j = (rr + k) % N;
                if (win < 0 && p_v[j] && (!p_ld[j] || !full)) win = j;
            end
        end
        exp_rdy = (win >= 0) ? N'(1 << win) : '0;
        check("cu_req_ready", cu_req_ready, exp_rdy);
        check("mem_req_valid", mem_req_valid, mo_v);
        if (mo_v) begin
            check("mem_req_is_load", mem_req_is_load, mo_ld);
            check("mem_req_addr", mem_req_addr, mo_addr);
            check("mem_req_wdata", mem_req_wdata, mo_wd);
            check("mem_req_rd", mem_req_rd, mo_rd);
        end
        check("cu_resp_valid", cu_resp_valid, mr_v);
        if (mr_v != '0) begin
            check("cu_resp_rd", cu_resp_rd, mr_rd);
            check("cu_resp_data", cu_resp_data, mr_data);
        end
        check("err_resp_underflow", err_resp_underflow, m_err);

        fire = mo_v && mem_req_ready;
        if (fire && mo_ld) begin
            mresp_t r;
            r.rd = mo_rd; r.data = $urandom; r.due = cyc + lat;
            mq.push_back(r);
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            mr_v = '0;
            if (mem_resp_valid) begin
                if (tags.size() == 0) begin
                    m_err = 1;
                end else begin
                    h = tags.pop_front();
                    mr_v = N'(1 << h); mr_rd = mem_resp_rd; mr_data = mem_resp_data;
                end
            end
            if (win >= 0) begin
                mo_v = 1; mo_ld = p_ld[win]; mo_addr = p_addr[win];
                mo_wd = p_wd[win]; mo_rd = p_rd[win];
                if (p_ld[win]) tags.push_back(win);
                rr = (win + 1) % N;
                p_v[win] = 0;
            end else if (fire) begin
                mo_v = 0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        mem_resp_valid = 0; mem_resp_rd = '0; mem_resp_data = '0;
        if (force_resp) begin
            mem_resp_valid = 1; mem_resp_rd = 5'($urandom); mem_resp_data = $urandom;
            force_resp = 0;
        end else if (resp_en && mq.size() > 0 && mq[0].due <= cyc
                     && $urandom_range(99) < resp_pct) begin
            mresp_t r;
            r = mq.pop_front();
            mem_resp_valid = 1; mem_resp_rd = r.rd; mem_resp_data = r.data;
        end
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        for (int i = 0; i < N; i++) begin
            if (!p_v[i] && $urandom_range(99) < gen_pct) begin
                p_v[i] = 1; p_ld[i] = ($urandom_range(99) < load_pct);
                p_addr[i] = $urandom; p_wd[i] = $urandom; p_rd[i] = 5'($urandom);
            end
        end
        drive_cu();
    endtask

    function automatic bit any_pending();
        bit a = 0;
        for (int i = 0; i < N; i++) a |= p_v[i];
        return a;
    endfunction

    task automatic drain();
        int n = 0;
        gen_pct = 0; rdy_pct = 100; resp_en = 1; resp_pct = 100;
        while ((mo_v || tags.size() > 0 || mq.size() > 0 || any_pending()) && n < 400) begin
            step();
            n++;
        end
        check("drain_in_budget", (n < 400), 1'b1);
        step();
        step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 0;
        cu_req_valid = '0; cu_req_is_load = '0; cu_req_addr = '0;
        cu_req_wdata = '0; cu_req_rd = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rd = '0; mem_resp_data = '0;
        for (int i = 0; i < N; i++) begin
            p_v[i] = 0; p_ld[i] = 0; p_addr[i] = '0; p_wd[i] = '0; p_rd[i] = '0;
        end
        gen_pct = 0; load_pct = 0; rdy_pct = 0; resp_pct = 100; lat = 3;
        resp_en = 1; force_resp = 0;
        model_reset();
        @(posedge clk);
        #1;
        run(2);
        rst_n = 1;

        // All CUs stream loads, memory always ready, responses 3 cycles out.
        gen_pct = 100; load_pct = 100; rdy_pct = 100; resp_pct = 100; lat = 3;
        run(40);
        drain();

        // CU2 store alongside a CU1 load.
        p_v[1] = 1; p_ld[1] = 1; p_addr[1] = 32'h0000_1234; p_wd[1] = '0; p_rd[1] = 5'd7;
        p_v[2] = 1; p_ld[2] = 0; p_addr[2] = 32'hFFFF_F9F0; p_wd[2] = 32'd1; p_rd[2] = 5'd3;
        drive_cu();
        drain();

        // Downstream back-pressure for 5 cycles with CU0 waiting.
        rdy_pct = 0;
        p_v[0] = 1; p_ld[0] = 1; p_addr[0] = 32'hA000_0000; p_wd[0] = '0; p_rd[0] = 5'd1;
        drive_cu();
        step();
        p_v[0] = 1; p_ld[0] = 1; p_addr[0] = 32'hA000_0004; p_rd[0] = 5'd2;
        drive_cu();
        run(5);
        rdy_pct = 100;
        run(4);
        drain();

        // Fill the tag FIFO with no responses, stores must still pass.
        resp_en = 0; gen_pct = 100; load_pct = 80; rdy_pct = 100;
        run(50);
        drain();

        // Spurious response with nothing outstanding.
        force_resp = 1;
        run(4);

        // Mixed random traffic with varied latency and back-pressure.
        for (int r = 0; r < 4; r++) begin
            gen_pct = 60; load_pct = 60; rdy_pct = 70; resp_pct = 70; resp_en = 1;
            lat = $urandom_range(1, 6);
            run(150);
        end
        drain();

        // Reset with loads in flight; their late responses are stale.
        gen_pct = 100; load_pct = 100; rdy_pct = 100; resp_pct = 100; lat = 6;
        run(8);
        rst_n = 0;
        gen_pct = 0;
        step();
        rst_n = 1;
        run(20);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
